// File: rtl/xlr8_dm_arb.sv
// xlr8_dm_arb: shares the single-port data memory between the AVR CPU port and one DMA port.
// Optional build macro XLR8_DM_ARB_STATS_EN adds the saturating CPU stall-cycle counter.
module xlr8_dm_arb #(
  parameter int MAX_STARVE = 4,
  parameter int ADDR_W     = 16
) (
  input  logic              cp2,
  input  logic              rst,
  input  logic              cpu_ce,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_din,
  output logic [7:0]        cpu_dout,
  output logic              cpu_wait,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [7:0]        dma_din,
  output logic              dma_gnt,
  output logic [7:0]        dma_dout,
  output logic              dma_rvalid,
  output logic              mem_ce,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_din,
  input  logic [7:0]        mem_dout,
  input  logic              stat_clr,
  output logic [15:0]       stall_cnt
);

  // state  | meaning
  // NORMAL | CPU has fixed priority; denied DMA cycles are counted
  // FORCE  | one-cycle DMA slot; the CPU access is held off and re-presented
  typedef enum logic {NORMAL = 1'b0, FORCE = 1'b1} state_t;

  localparam logic [7:0] STARVE_LIM = 8'(MAX_STARVE);

  state_t     state_q, state_d;
  logic [7:0] starve_q, starve_d;
  logic       rvalid_q;
  logic       force_s;

  assign force_s  = (state_q == FORCE);
  assign cpu_wait = force_s;
  assign dma_gnt  = dma_req & (~cpu_ce | force_s);

  assign mem_ce   = dma_gnt | (cpu_ce & ~force_s);
  assign mem_addr = dma_gnt ? dma_addr : cpu_addr;
  assign mem_din  = dma_gnt ? dma_din  : cpu_din;
  assign mem_we   = dma_gnt ? dma_we   : (cpu_we & cpu_ce & ~force_s);

  // Read data is a plain passthrough; only the registered rvalid qualifies it.
  assign cpu_dout   = mem_dout;
  assign dma_dout   = mem_dout;
  assign dma_rvalid = rvalid_q;

  always_comb begin
    state_d  = NORMAL;
    starve_d = '0;
    if ((state_q == NORMAL) && dma_req && !dma_gnt) begin
      if (starve_q + 8'd1 == STARVE_LIM) begin
        state_d = FORCE;
      end else begin
        starve_d = starve_q + 8'd1;
      end
    end
  end

  always_ff @(posedge cp2 or posedge rst) begin
    if (rst) begin
      state_q  <= NORMAL;
      starve_q <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      rvalid_q <= dma_gnt & ~dma_we;
    end
  end

`ifdef XLR8_DM_ARB_STATS_EN
  logic [15:0] stall_q;

  always_ff @(posedge cp2 or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else if (stat_clr) begin
      stall_q <= '0;
    end else if (force_s && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
`else
  logic unused_stat_clr;
  assign unused_stat_clr = stat_clr;
  assign stall_cnt       = '0;
`endif

endmodule

// File: tb/tb_xlr8_dm_arb.sv
// Scoreboard bench for xlr8_dm_arb: directed stimulus pushes expected read data,
// a monitor pops it whenever the DUT presents a CPU or DMA read result.
module tb_xlr8_dm_arb;
  localparam int MAX = 4;
  localparam int AW  = 16;

  logic          cp2 = 1'b0;
  logic          rst = 1'b1;
  logic          cpu_ce = 0, cpu_we = 0;
  logic [AW-1:0] cpu_addr = '0;
  logic [7:0]    cpu_din = '0;
  logic [7:0]    cpu_dout;
  logic          cpu_wait;
  logic          dma_req = 0, dma_we = 0;
  logic [AW-1:0] dma_addr = '0;
  logic [7:0]    dma_din = '0;
  logic          dma_gnt;
  logic [7:0]    dma_dout;
  logic          dma_rvalid;
  logic          mem_ce, mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_din;
  logic [7:0]    mem_dout = '0;
  logic          stat_clr = 0;
  logic [15:0]   stall_cnt;

  logic [7:0]    ram [0:65535];
  logic [7:0]    cpu_q [$];
  logic [7:0]    dma_q [$];
  logic [15:0]   exp_stall = '0;
  bit            cpu_rd_prev = 0;
  int            checks = 0;
  int            failures = 0;

  xlr8_dm_arb #(.MAX_STARVE(MAX), .ADDR_W(AW)) dut (
    .cp2(cp2), .rst(rst),
    .cpu_ce(cpu_ce), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_dout(cpu_dout), .cpu_wait(cpu_wait),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_din(dma_din),
    .dma_gnt(dma_gnt), .dma_dout(dma_dout), .dma_rvalid(dma_rvalid),
    .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout), .stat_clr(stat_clr), .stall_cnt(stall_cnt)
  );

  always #5 cp2 = ~cp2;

  // RAM model: synchronous write, registered-address read.
  always @(posedge cp2) begin
    if (mem_ce) begin
      if (mem_we) ram[mem_addr] <= mem_din;
      mem_dout <= ram[mem_addr];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard whenever a read result is on the bus.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge cp2);
      #2;
      if (cpu_rd_prev) begin
        if (cpu_q.size() == 0) chk("cpu_rd_unexpected", 1, 0);
        else begin
          e = cpu_q.pop_front();
          chk("cpu_dout", cpu_dout, e);
        end
      end
      if (dma_rvalid) begin
        if (dma_q.size() == 0) chk("dma_rvalid_unexpected", 1, 0);
        else begin
          e = dma_q.pop_front();
          chk("dma_dout", dma_dout, e);
        end
      end
      cpu_rd_prev = cpu_ce && !cpu_we && !cpu_wait && !dma_gnt && !rst;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic idle();
    @(negedge cp2);
    cpu_ce = 0; cpu_we = 0; dma_req = 0; dma_we = 0; stat_clr = 0;
    #1;
  endtask

  // n forced slots under continuous contention; mode 1 resets in the last
  // FORCE cycle, mode 2 drops dma_req in the last FORCE cycle.
  task automatic contend(input int n, input int mode, input logic [15:0] ca,
                         input logic [7:0] cexp, input logic [15:0] da,
                         input logic [7:0] dexp);
    for (int k = 0; k < n; k++) begin
      for (int j = 0; j < MAX; j++) begin
        @(negedge cp2);
        cpu_ce = 1; cpu_we = 0; cpu_addr = ca;
        dma_req = 1; dma_we = 0; dma_addr = da;
        #1;
        chk("denied_gnt", dma_gnt, 0);
        chk("denied_wait", cpu_wait, 0);
        chk("cpu_slot_addr", mem_addr, ca);
        cpu_q.push_back(cexp);
      end
      @(negedge cp2);
      if (mode == 2 && k == n - 1) dma_req = 0;
      #1;
      chk("force_wait", cpu_wait, 1);
      if (mode == 2 && k == n - 1) begin
        chk("viol_gnt", dma_gnt, 0);
        chk("viol_mem_ce", mem_ce, 0);
      end else begin
        chk("force_gnt", dma_gnt, 1);
        chk("force_addr", mem_addr, da);
        chk("force_we", mem_we, 0);
      end
      if (mode == 1 && k == n - 1) begin
        #2 rst = 1;
        #1;
        chk("rst_wait", cpu_wait, 0);
        chk("rst_rvalid", dma_rvalid, 0);
        chk("rst_gnt", dma_gnt, 0);
        chk("rst_stall", stall_cnt, 0);
        exp_stall = '0;
        @(negedge cp2);
        rst = 0; cpu_ce = 0; dma_req = 0;
        #1;
        chk("post_rst_wait", cpu_wait, 0);
        chk("post_rst_rvalid", dma_rvalid, 0);
      end else begin
        if (mode != 2 || k != n - 1) dma_q.push_back(dexp);
`ifdef XLR8_DM_ARB_STATS_EN
        if (exp_stall != 16'hFFFF) exp_stall = exp_stall + 16'd1;
`endif
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
    ram[16'h0123] = 8'h5A;
    ram[16'h0300] = 8'h3C;

    #1;
    chk("reset_wait", cpu_wait, 0);
    chk("reset_rvalid", dma_rvalid, 0);
    chk("reset_gnt", dma_gnt, 0);
    chk("reset_stall", stall_cnt, 0);
    @(negedge cp2);
    rst = 0;

    // DMA read with CPU idle
    @(negedge cp2);
    dma_req = 1; dma_we = 0; dma_addr = 16'h0123;
    #1;
    chk("t1_gnt", dma_gnt, 1);
    chk("t1_addr", mem_addr, 16'h0123);
    chk("t1_ce", mem_ce, 1);
    chk("t1_we", mem_we, 0);
    dma_q.push_back(8'h5A);
    @(negedge cp2);
    dma_req = 0;
    #1 chk("t1_rvalid_c1", dma_rvalid, 1);
    @(negedge cp2);
    #1 chk("t1_rvalid_c2", dma_rvalid, 0);

    // Contention: two forced slots, count restarts after each
    contend(2, 0, 16'h0123, 8'h5A, 16'h0300, 8'h3C);
    idle();
    chk("t2_wait_after", cpu_wait, 0);
    chk("t2_stall", stall_cnt, exp_stall);

    // Same-cycle writes to one address
    @(negedge cp2);
    cpu_ce = 1; cpu_we = 1; cpu_addr = 16'h0040; cpu_din = 8'h11;
    dma_req = 1; dma_we = 1; dma_addr = 16'h0040; dma_din = 8'h22;
    #1;
    chk("t3_cpu_gnt", dma_gnt, 0);
    chk("t3_cpu_we", mem_we, 1);
    chk("t3_cpu_din", mem_din, 8'h11);
    chk("t3_cpu_addr", mem_addr, 16'h0040);
    @(negedge cp2);
    cpu_ce = 0; cpu_we = 0;
    #1;
    chk("t3_dma_gnt", dma_gnt, 1);
    chk("t3_dma_we", mem_we, 1);
    chk("t3_dma_din", mem_din, 8'h22);
    @(negedge cp2);
    dma_req = 0; dma_we = 0; cpu_ce = 1; cpu_addr = 16'h0040;
    #1 chk("t3_no_rvalid", dma_rvalid, 0);
    cpu_q.push_back(8'h22);
    idle();

    // DMA write then CPU read-back
    @(negedge cp2);
    dma_req = 1; dma_we = 1; dma_addr = 16'h0200; dma_din = 8'hA5;
    #1;
    chk("t4_gnt", dma_gnt, 1);
    chk("t4_we", mem_we, 1);
    chk("t4_addr", mem_addr, 16'h0200);
    @(negedge cp2);
    dma_req = 0; dma_we = 0; cpu_ce = 1; cpu_we = 0; cpu_addr = 16'h0200;
    #1 chk("t4_rvalid", dma_rvalid, 0);
    cpu_q.push_back(8'hA5);
    idle();
    chk("t4_rvalid_late", dma_rvalid, 0);

    // Reset during FORCE, then a full MAX-cycle starvation window
    contend(1, 1, 16'h0123, 8'h5A, 16'h0300, 8'h3C);
    contend(1, 0, 16'h0123, 8'h5A, 16'h0300, 8'h3C);
    idle();
    chk("t5_stall", stall_cnt, exp_stall);

    // Protocol violation: dma_req dropped inside FORCE
    contend(1, 2, 16'h0123, 8'h5A, 16'h0300, 8'h3C);
    idle();
    chk("viol_wait_after", cpu_wait, 0);
    chk("viol_stall", stall_cnt, exp_stall);

    // Stall counter: clear, three slots, saturation
    @(negedge cp2);
    stat_clr = 1;
    idle();
    exp_stall = '0;
    chk("t6_clr", stall_cnt, exp_stall);
    contend(3, 0, 16'h0200, 8'hA5, 16'h0123, 8'h5A);
    idle();
    chk("t6_three", stall_cnt, exp_stall);
`ifdef XLR8_DM_ARB_STATS_EN
    @(negedge cp2);
    dut.stall_q = 16'hFFFF;
    exp_stall = 16'hFFFF;
`endif
    contend(1, 0, 16'h0200, 8'hA5, 16'h0123, 8'h5A);
    idle();
    chk("t6_sat", stall_cnt, exp_stall);

    idle();
    idle();
    chk("cpu_q_empty", cpu_q.size(), 0);
    chk("dma_q_empty", dma_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
